// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and pointer-rotate helper for the round-robin arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int ARB_MAX_N = 64;
  function automatic logic [ARB_MAX_N-1:0] rotl1(input logic [ARB_MAX_N-1:0] v, input int n);
    rotl1 = '0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (i < n) rotl1[i] = v[i == 0 ? n - 1 : i - 1];
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating find-first starting at one-hot ptr
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);
  localparam int W = 2 * N;
  logic [W-1:0] dbl, first;
  // lower copy keeps only bits at/above ptr; upper copy supplies the wrap-around
  always_comb begin
    dbl   = {req, req & ~(ptr - N'(1))};
    first = dbl & (~dbl + W'(1));
    gnt   = first[N-1:0] | first[W-1:N];
  end
endmodule

// File: rtl/rr_arb_1hot.sv
// rr_arb_1hot: round-robin one-hot arbiter with valid/ready handshake and packet lock
module rr_arb_1hot
  import arb_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter bit LOCK   = 1'b1,
  localparam int IW    = $clog2(INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] req_valid,
  input  logic [INPUTS-1:0] req_last,
  output logic [INPUTS-1:0] req_ready,
  output logic [INPUTS-1:0] gnt,
  output logic [IW-1:0]     gnt_id,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);
  arb_state_t st_q, st_d;
  logic [INPUTS-1:0] ptr_q, ptr_d, hold_q, hold_d, pick;
  logic [ARB_MAX_N-1:0] rot;
  logic xfer, done;
  rr_pick #(.N(INPUTS)) u_pick (.req(req_valid), .ptr(ptr_q), .gnt(pick));
  always_comb begin
    gnt       = (st_q == ARB_BUSY) ? hold_q : pick;
    out_valid = |(gnt & req_valid);
    out_last  = |(gnt & req_last & req_valid);
    req_ready = gnt & {INPUTS{out_ready}};
    xfer      = out_valid & out_ready;
    done      = xfer & (out_last | !LOCK);
    gnt_id    = '0;
    for (int i = 0; i < INPUTS; i++)
      if (gnt[i]) gnt_id = gnt_id | IW'(i);
  end
  // any granted beat that does not complete the packet pins the grant
  always_comb begin
    rot    = rotl1(ARB_MAX_N'(gnt), INPUTS);
    st_d   = done ? ARB_IDLE : ((|gnt) ? ARB_BUSY : st_q);
    hold_d = (!done && st_q == ARB_IDLE && |gnt) ? gnt : hold_q;
    ptr_d  = done ? rot[INPUTS-1:0] : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ARB_IDLE;
      ptr_q  <= INPUTS'(1);
      hold_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end
`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n) (out_valid && !out_ready) |=> $stable(gnt));
  a_ready:  assert property (@(posedge clk) disable iff (!rst_n) (req_ready & ~gnt) == '0);
`endif
endmodule

// File: tb/tb_rr_arb_1hot.sv
// tb_rr_arb_1hot: LOCK=0 and LOCK=1 arbiters against a queue-free index-based reference model
module tb_rr_arb_1hot;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rv[2], rl[2], rr[2], gn[2], acc[2];
  logic [1:0] gid[2];
  logic ov[2], ol[2], ordy[2];
  int checks = 0, failures = 0;
  int mptr[2], mown[2], rem[2][N], sent[N];
  logic [N-1:0] alt[4];

  rr_arb_1hot #(.INPUTS(N), .LOCK(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_last(rl[0]), .req_ready(rr[0]),
    .gnt(gn[0]), .gnt_id(gid[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_ready(ordy[0]));
  rr_arb_1hot #(.INPUTS(N), .LOCK(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_last(rl[1]), .req_ready(rr[1]),
    .gnt(gn[1]), .gnt_id(gid[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_ready(ordy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int egnt(input int d);
    if (mown[d] >= 0) return mown[d];
    for (int k = 0; k < N; k++)
      if (rv[d][(mptr[d] + k) % N]) return (mptr[d] + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] eoh(input int g);
    return g < 0 ? '0 : N'(1) << g;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      mown[d] = -1;
      acc[d]  = '0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      int g;
      logic ev, el;
      g  = egnt(d);
      ev = g >= 0 && rv[d][g];
      el = ev && rl[d][g];
      chk($sformatf("%s.d%0d.gnt", tag, d), 32'(gn[d]), 32'(eoh(g)));
      chk($sformatf("%s.d%0d.gnt_id", tag, d), 32'(gid[d]), g < 0 ? 0 : g);
      chk($sformatf("%s.d%0d.out_valid", tag, d), 32'(ov[d]), 32'(ev));
      chk($sformatf("%s.d%0d.out_last", tag, d), 32'(ol[d]), 32'(el));
      chk($sformatf("%s.d%0d.req_ready", tag, d), 32'(rr[d]), 32'(eoh(g) & {N{ordy[d]}}));
    end
  endtask

  task automatic tick(input string tag);
    #1 check_all(tag);
    for (int d = 0; d < 2; d++) begin
      int g;
      logic x;
      g = egnt(d);
      x = g >= 0 && rv[d][g] && ordy[d];
      acc[d] = x ? eoh(g) : '0;
      if (x && (rl[d][g] || d == 0)) begin
        mptr[d] = (g + 1) % N;
        mown[d] = -1;
      end else if (g >= 0) mown[d] = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic both(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    for (int d = 0; d < 2; d++) begin
      rv[d] = v;
      rl[d] = l;
      ordy[d] = r;
    end
  endtask

  task automatic drive(input int d);
    for (int i = 0; i < N; i++) begin
      if (acc[d][i]) begin
        rem[d][i]--;
        rv[d][i] = 1'b0;
      end
      if (!rv[d][i]) begin
        if (rem[d][i] == 0 && $urandom_range(0, 2) == 0) rem[d][i] = $urandom_range(1, 3);
        rv[d][i] = rem[d][i] > 0 && $urandom_range(0, 3) != 0;
      end
      rl[d][i] = rem[d][i] == 1;
    end
    ordy[d] = $urandom_range(0, 9) < 7;
  endtask

  initial begin
    model_reset();
    both('0, '0, 1'b0);
    #12 check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    both('1, '1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #2 chk($sformatf("all_valid.gnt%0d", k), 32'(gn[1]), 32'(N'(1) << k));
      chk($sformatf("all_valid.id%0d", k), 32'(gid[1]), k);
      tick("all_valid");
    end
    both(4'b0001, 4'b0001, 1'b1);
    tick("pre_lock");
    for (int k = 0; k < 3; k++) begin
      both(4'b0111, k == 2 ? 4'b0111 : 4'b0101, 1'b1);
      #2 chk($sformatf("lock.beat%0d", k), 32'(gn[1]), 32'h2);
      tick("lock");
    end
    both(4'b0101, 4'b0101, 1'b1);
    #2 chk("lock.next_in2", 32'(gn[1]), 32'h4);
    tick("lock_next");
    both(4'b0001, 4'b0001, 1'b1);
    tick("lock_in0");
    both(4'b0100, 4'b0100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) rv[0][0] = 1'b1;
      if (k == 5) rv[1][0] = 1'b1;
      #2 chk($sformatf("bp.hold%0d", k), 32'(gn[1]), 32'h4);
      tick("backpressure");
    end
    both(4'b0101, 4'b0101, 1'b1);
    tick("bp_accept");
    both(4'b0001, 4'b0001, 1'b1);
    tick("bp_in0");
    both(4'b1000, 4'b0000, 1'b1);
    tick("bubble_b1");
    for (int k = 0; k < 2; k++) begin
      both(4'b0001, 4'b0001, 1'b1);
      #2 chk($sformatf("bubble.gnt%0d", k), 32'(gn[1]), 32'h8);
      chk($sformatf("bubble.ov%0d", k), 32'(ov[1]), 32'h0);
      tick("bubble");
    end
    both(4'b1001, 4'b1001, 1'b1);
    tick("bubble_last");
    both(4'b0001, 4'b0001, 1'b1);
    tick("bubble_in0");
    both(4'b0100, 4'b0000, 1'b1);
    tick("mid_pkt");
    rst_n = 1'b0;
    both('1, '1, 1'b1);
    model_reset();
    #1 check_all("rst_mid");
    chk("rst_mid.gnt", 32'(gn[1]), 32'h1);
    both('0, '0, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    alt[0] = 4'b0001;
    alt[1] = 4'b0010;
    alt[2] = 4'b0001;
    alt[3] = 4'b0010;
    for (int i = 0; i < N; i++) sent[i] = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        rv[0][i] = i < 2 && sent[i] < 2;
        rl[0][i] = sent[i] == 1;
      end
      #2 chk($sformatf("nolock.gnt%0d", k), 32'(gn[0]), 32'(alt[k]));
      tick("nolock");
      for (int i = 0; i < N; i++) sent[i] += int'(acc[0][i]);
    end
    both('0, '0, 1'b0);
    tick("idle");
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0;
      for (int i = 0; i < N; i++) rem[d][i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      drive(0);
      drive(1);
      tick("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
